// File: rtl/vx_issue_perf_counters.sv
// Issue-stage performance counters.
//
// This block samples stall and dispatch-fire events from every issue slot. It
// reduces them to per-cycle deltas in stage 1. In stage 2 it adds those
// deltas to free-running wrap-around counters, which the CSR unit reads.
//
// Ports
//    clk, reset_n     clock, asynchronous active-low reset
//    perf_enable      sample events only while high
//    ibf_stall        per-slot instruction-buffer stall
//    scb_stall        per-slot scoreboard stall
//    disp_valid/ready per-slot dispatch handshake (fire = valid & ready)
//    disp_ex_type     per-slot execution-unit type, EX_BITS each
//    disp_sfu_type    per-slot SFU sub-type, SFU_BITS each
//    disp_tmask       per-slot thread mask, NUM_THREADS each
//    ibf_stalls       accumulated ibf stall slot-cycles
//    scb_stalls       accumulated scoreboard stall slot-cycles
//    units_uses       per-unit dispatch counts, unit i at [i*PERF_CTR_BITS +: PERF_CTR_BITS]
//    sfu_uses         per-SFU-type dispatch counts, same packing
//    active_threads   accumulated popcount of dispatched thread masks
module vx_issue_perf_counters #(
   parameter int ISSUE_WIDTH   = 4,
   parameter int NUM_THREADS   = 4,
   parameter int NUM_EX_UNITS  = 4,
   parameter int NUM_SFU_UNITS = 2,
   parameter int EX_BITS       = 2,
   parameter int SFU_BITS      = 1,
   parameter int SFU_EX_ID     = 3,
   parameter int PERF_CTR_BITS = 44
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic                                   perf_enable,
   input  logic [ISSUE_WIDTH-1:0]                 ibf_stall,
   input  logic [ISSUE_WIDTH-1:0]                 scb_stall,
   input  logic [ISSUE_WIDTH-1:0]                 disp_valid,
   input  logic [ISSUE_WIDTH-1:0]                 disp_ready,
   input  logic [ISSUE_WIDTH*EX_BITS-1:0]         disp_ex_type,
   input  logic [ISSUE_WIDTH*SFU_BITS-1:0]        disp_sfu_type,
   input  logic [ISSUE_WIDTH*NUM_THREADS-1:0]     disp_tmask,
   output logic [PERF_CTR_BITS-1:0]               ibf_stalls,
   output logic [PERF_CTR_BITS-1:0]               scb_stalls,
   output logic [NUM_EX_UNITS*PERF_CTR_BITS-1:0]  units_uses,
   output logic [NUM_SFU_UNITS*PERF_CTR_BITS-1:0] sfu_uses,
   output logic [PERF_CTR_BITS-1:0]               active_threads
);

   localparam int SLOT_W = $clog2(ISSUE_WIDTH + 1);
   localparam int THR_W  = $clog2(ISSUE_WIDTH * NUM_THREADS + 1);

   logic [ISSUE_WIDTH-1:0] fire;

   // stage 1: per-cycle deltas
   logic                                   valid_d, valid_q;
   logic [SLOT_W-1:0]                      ibf_delta_d, ibf_delta_q;
   logic [SLOT_W-1:0]                      scb_delta_d, scb_delta_q;
   logic [NUM_EX_UNITS-1:0][SLOT_W-1:0]    unit_delta_d, unit_delta_q;
   logic [NUM_SFU_UNITS-1:0][SLOT_W-1:0]   sfu_delta_d, sfu_delta_q;
   logic [THR_W-1:0]                       thr_delta_d, thr_delta_q;

   // stage 2: running counters
   logic [PERF_CTR_BITS-1:0]                      ibf_cnt_d, ibf_cnt_q;
   logic [PERF_CTR_BITS-1:0]                      scb_cnt_d, scb_cnt_q;
   logic [NUM_EX_UNITS-1:0][PERF_CTR_BITS-1:0]    unit_cnt_d, unit_cnt_q;
   logic [NUM_SFU_UNITS-1:0][PERF_CTR_BITS-1:0]   sfu_cnt_d, sfu_cnt_q;
   logic [PERF_CTR_BITS-1:0]                      thr_cnt_d, thr_cnt_q;

   assign fire = disp_valid & disp_ready;

   always_comb begin
      valid_d      = perf_enable;
      ibf_delta_d  = '0;
      scb_delta_d  = '0;
      unit_delta_d = '0;
      sfu_delta_d  = '0;
      thr_delta_d  = '0;
      if (perf_enable) begin
         for (int s = 0; s < ISSUE_WIDTH; s++) begin
            ibf_delta_d = ibf_delta_d + SLOT_W'(ibf_stall[s]);
            scb_delta_d = scb_delta_d + SLOT_W'(scb_stall[s]);
            if (fire[s]) begin
               // Out-of-range ex_type values match no unit index and drop out.
               for (int u = 0; u < NUM_EX_UNITS; u++) begin
                  if (disp_ex_type[s*EX_BITS +: EX_BITS] == EX_BITS'(u))
                     unit_delta_d[u] = unit_delta_d[u] + SLOT_W'(1'b1);
               end
               if (disp_ex_type[s*EX_BITS +: EX_BITS] == EX_BITS'(SFU_EX_ID)) begin
                  for (int k = 0; k < NUM_SFU_UNITS; k++) begin
                     if (disp_sfu_type[s*SFU_BITS +: SFU_BITS] == SFU_BITS'(k))
                        sfu_delta_d[k] = sfu_delta_d[k] + SLOT_W'(1'b1);
                  end
               end
               for (int t = 0; t < NUM_THREADS; t++)
                  thr_delta_d = thr_delta_d + THR_W'(disp_tmask[s*NUM_THREADS+t]);
            end
         end
      end
   end

   // Stage 1 still holds a delta that was sampled before enable dropped. That
   // delta is added here no matter what perf_enable is now.
   always_comb begin
      ibf_cnt_d  = ibf_cnt_q;
      scb_cnt_d  = scb_cnt_q;
      unit_cnt_d = unit_cnt_q;
      sfu_cnt_d  = sfu_cnt_q;
      thr_cnt_d  = thr_cnt_q;
      if (valid_q) begin
         ibf_cnt_d = ibf_cnt_q + PERF_CTR_BITS'(ibf_delta_q);
         scb_cnt_d = scb_cnt_q + PERF_CTR_BITS'(scb_delta_q);
         thr_cnt_d = thr_cnt_q + PERF_CTR_BITS'(thr_delta_q);
         for (int u = 0; u < NUM_EX_UNITS; u++)
            unit_cnt_d[u] = unit_cnt_q[u] + PERF_CTR_BITS'(unit_delta_q[u]);
         for (int k = 0; k < NUM_SFU_UNITS; k++)
            sfu_cnt_d[k] = sfu_cnt_q[k] + PERF_CTR_BITS'(sfu_delta_q[k]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q      <= 1'b0;
         ibf_delta_q  <= '0;
         scb_delta_q  <= '0;
         unit_delta_q <= '0;
         sfu_delta_q  <= '0;
         thr_delta_q  <= '0;
         ibf_cnt_q    <= '0;
         scb_cnt_q    <= '0;
         unit_cnt_q   <= '0;
         sfu_cnt_q    <= '0;
         thr_cnt_q    <= '0;
      end else begin
         valid_q      <= valid_d;
         ibf_delta_q  <= ibf_delta_d;
         scb_delta_q  <= scb_delta_d;
         unit_delta_q <= unit_delta_d;
         sfu_delta_q  <= sfu_delta_d;
         thr_delta_q  <= thr_delta_d;
         ibf_cnt_q    <= ibf_cnt_d;
         scb_cnt_q    <= scb_cnt_d;
         unit_cnt_q   <= unit_cnt_d;
         sfu_cnt_q    <= sfu_cnt_d;
         thr_cnt_q    <= thr_cnt_d;
      end
   end

   assign ibf_stalls     = ibf_cnt_q;
   assign scb_stalls     = scb_cnt_q;
   assign active_threads = thr_cnt_q;

   for (genvar u = 0; u < NUM_EX_UNITS; u++) begin : g_units
      assign units_uses[u*PERF_CTR_BITS +: PERF_CTR_BITS] = unit_cnt_q[u];
   end

   for (genvar k = 0; k < NUM_SFU_UNITS; k++) begin : g_sfu
      assign sfu_uses[k*PERF_CTR_BITS +: PERF_CTR_BITS] = sfu_cnt_q[k];
   end

endmodule

// File: doc/vx_issue_perf_counters.md
Name: vx_issue_perf_counters

Overview:
Accumulates per-cycle issue-stage performance events into the running counters carried by the pipeline perf interface (issue-side signals: ibf_stalls, scb_stalls, units_uses, sfu_uses, active_threads). Sits beside the issue/dispatch logic. Samples per-slot stall and dispatch-fire events from all issue slots, reduces them to per-cycle deltas, and adds them to wrap-around counters. The counters are read by the CSR unit.

Parameters:
ISSUE_WIDTH, 4, number of issue slots sampled per cycle
NUM_THREADS, 4, threads per warp (thread-mask width)
NUM_EX_UNITS, 4, number of execution-unit types counted
NUM_SFU_UNITS, 2, number of SFU sub-unit types counted
EX_BITS, 2, width of an execution-unit type code
SFU_BITS, 1, width of an SFU sub-type code
SFU_EX_ID, 3, ex_type value that identifies the SFU
PERF_CTR_BITS, 44, counter width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
perf_enable  in  1  counting enable; events sampled only when high
ibf_stall  in  ISSUE_WIDTH  per slot: instruction buffer stalled this cycle
scb_stall  in  ISSUE_WIDTH  per slot: scoreboard stalled this cycle
disp_valid  in  ISSUE_WIDTH  per slot: dispatch valid
disp_ready  in  ISSUE_WIDTH  per slot: dispatch ready (fire = valid & ready)
disp_ex_type  in  ISSUE_WIDTH*EX_BITS  per-slot execution-unit type
disp_sfu_type  in  ISSUE_WIDTH*SFU_BITS  per-slot SFU sub-type; meaningful only when ex_type==SFU_EX_ID
disp_tmask  in  ISSUE_WIDTH*NUM_THREADS  per-slot active thread mask
ibf_stalls  out  PERF_CTR_BITS  accumulated ibf stall slot-cycles
scb_stalls  out  PERF_CTR_BITS  accumulated scoreboard stall slot-cycles
units_uses  out  NUM_EX_UNITS*PERF_CTR_BITS  per-unit dispatch count; unit i at bits [i*PERF_CTR_BITS +: PERF_CTR_BITS]
sfu_uses  out  NUM_SFU_UNITS*PERF_CTR_BITS  per-SFU-type dispatch count; same packing as units_uses
active_threads  out  PERF_CTR_BITS  accumulated popcount of dispatched thread masks

Behaviour:
- Reset: reset_n low asynchronously clears every counter, every stage-1 delta register and the stage-1 valid flag. All outputs read 0 while reset_n is low and in the first cycle after release.
- Fire: fire[s] = disp_valid[s] & disp_ready[s]. Valid without ready counts nothing.
- Stage 1 (registered, one per cycle, only when perf_enable=1):
  - d_ibf = popcount(ibf_stall); d_scb = popcount(scb_stall).
  - d_unit[u] = number of fired slots with ex_type==u.
  - d_sfu[k] = number of fired slots with ex_type==SFU_EX_ID and sfu_type==k.
  - d_thr = sum over fired slots of popcount(tmask).
  - Widths: slot deltas $clog2(ISSUE_WIDTH+1); d_thr $clog2(ISSUE_WIDTH*NUM_THREADS+1).
  - When perf_enable=0, all stage-1 deltas register as 0.
- Stage 2: each counter += its zero-extended stage-1 delta every cycle.
- Latency: an event sampled at edge N appears in the outputs after edge N+1. Outputs are counters, so there is no backpressure.
- Wrap-around: counters roll over modulo 2^PERF_CTR_BITS with no saturation and no sticky flag.
- ex_type >= NUM_EX_UNITS: ignored, no counter changes. sfu_type >= NUM_SFU_UNITS: ignored for sfu_uses, but still counted in units_uses[SFU_EX_ID].
- A slot may assert ibf_stall, scb_stall and fire in the same cycle; each is counted independently.
- perf_enable falling: a delta already held in stage 1 is still added on the next edge, so no sampled event is lost. perf_enable rising: counting resumes from the held values, with no clear.
- Reset mid-operation: the pending stage-1 delta is discarded; counters return to 0.
- All outputs are driven directly from flops.

Test Plan:
- Reset: hold reset_n=0 mid-count with counters nonzero -> all outputs 0 immediately (asynchronous); after release with no events, outputs stay 0.
- Stall latency: perf_enable=1, ibf_stall=4'b1011 for one cycle at edge N -> ibf_stalls=3 after edge N+1 and stays 3; scb_stalls remains 0.
- Dispatch mix: one cycle with all 4 slots valid; ready=4'b0111; ex_type={3,3,1,0}; sfu_type={1,0,x,x}; tmask={F,3,1,F} (slot3..slot0) -> units_uses[0]=1, [1]=1, [3]=1 (slot 3 not ready); sfu_uses[0]=1, sfu_uses[1]=0; active_threads=4+1+2=7.
- Enable gating: events on every slot for 10 cycles with perf_enable toggling 1,1,0,0,1,... -> counts reflect only the enabled cycles; an event sampled at the last enabled edge is still added after enable drops.
- Wrap: PERF_CTR_BITS=8, all 4 ibf_stall high for 64 cycles -> ibf_stalls wraps to 0, then reads 4 one cycle later.
- Out-of-range ex_type: with NUM_EX_UNITS=3, a fired slot with ex_type=3 -> no units_uses counter changes; active_threads still increments by that slot's popcount.
